// File: rtl/dmem_resp.sv
// dmem_resp: single-outstanding data-memory request/response block.
// A request is accepted in IDLE, waits LATENCY cycles in WAIT, then the
// store commits / load reads on the WAIT-to-RESP edge and the response is
// held in RESP until the consumer takes it.
module dmem_resp #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [2:0]  req_size,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);
    localparam int         WORDS    = 1 << ADDR_W;

    // Access is illegal for size 111, sub-word-extended stores, or misalignment.
    function automatic logic calc_err(input logic wen, input logic [2:0] size,
                                      input logic [2:0] off);
        logic bad;
        bad = 1'b0;
        case (size[1:0])
            2'b00:   bad = 1'b0;
            2'b01:   bad = off[0];
            2'b10:   bad = (off[1:0] != 2'b00);
            2'b11:   bad = (off != 3'b000);
            default: bad = 1'b1;
        endcase
        if (size == 3'b111) begin
            bad = 1'b1;
        end else if (wen && size[2]) begin
            bad = 1'b1;
        end else begin
            bad = bad;
        end
        return bad;
    endfunction

    // Byte mask of the access width, right-aligned.
    function automatic logic [63:0] size_mask(input logic [1:0] sz);
        logic [63:0] m;
        case (sz)
            2'b00:   m = 64'h0000_0000_0000_00FF;
            2'b01:   m = 64'h0000_0000_0000_FFFF;
            2'b10:   m = 64'h0000_0000_FFFF_FFFF;
            2'b11:   m = 64'hFFFF_FFFF_FFFF_FFFF;
            default: m = 64'h0000_0000_0000_0000;
        endcase
        return m;
    endfunction

    // Sign- or zero-extend the right-aligned load bytes to 64 bits.
    function automatic logic [63:0] extend_load(input logic [63:0] raw,
                                                input logic [2:0] size);
        logic [63:0] res;
        case (size)
            3'b000:  res = {{56{raw[7]}}, raw[7:0]};
            3'b001:  res = {{48{raw[15]}}, raw[15:0]};
            3'b010:  res = {{32{raw[31]}}, raw[31:0]};
            3'b011:  res = raw;
            3'b100:  res = {56'd0, raw[7:0]};
            3'b101:  res = {48'd0, raw[15:0]};
            3'b110:  res = {32'd0, raw[31:0]};
            default: res = 64'd0;
        endcase
        return res;
    endfunction

    state_t      state_r, state_s;
    logic [3:0]  cnt_r, cnt_s;
    logic        ready_r;
    logic        wen_r;
    logic [ADDR_W+2:0] addr_r;
    logic [63:0] wdata_r;
    logic [2:0]  size_r;
    logic        resp_valid_r;
    logic [63:0] rdata_r;
    logic        err_r;

    logic [63:0] mem [0:WORDS-1];

    logic              accept_s;
    logic              commit_s;
    logic [ADDR_W-1:0] idx_s;
    logic [2:0]        off_s;
    logic [5:0]        sh_s;
    logic              err_s;
    logic [63:0]       old_word_s;
    logic [63:0]       wmask_s;
    logic [63:0]       merged_s;
    logic [63:0]       load_s;
    logic              unused_addr_s;

    // Upper address bits wrap and are deliberately ignored.
    assign unused_addr_s = ^req_addr[63:ADDR_W+3];

    assign req_ready  = ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_rdata = rdata_r;
    assign resp_err   = err_r;

    assign accept_s   = req_valid & ready_r;
    assign commit_s   = (state_r == WAIT) && (cnt_r == 4'd0);
    assign idx_s      = addr_r[ADDR_W+2:3];
    assign off_s      = addr_r[2:0];
    assign sh_s       = {off_s, 3'b000};
    assign err_s      = calc_err(wen_r, size_r, off_s);
    assign old_word_s = mem[idx_s];
    assign wmask_s    = size_mask(size_r[1:0]) << sh_s;
    assign merged_s   = (old_word_s & ~wmask_s) | ((wdata_r << sh_s) & wmask_s);
    assign load_s     = extend_load(old_word_s >> sh_s, size_r);

    // Next-state and wait-counter logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    state_s = WAIT;
                    cnt_s   = CNT_LOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_s = RESP;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // State, counter and registered req_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            ready_r <= 1'b1;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            ready_r <= (state_s == IDLE);
        end
    end

    // Capture the request fields at acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            wen_r   <= 1'b0;
            addr_r  <= '0;
            wdata_r <= 64'd0;
            size_r  <= 3'd0;
        end else if (accept_s) begin
            wen_r   <= req_wen;
            addr_r  <= req_addr[ADDR_W+2:0];
            wdata_r <= req_wdata;
            size_r  <= req_size;
        end
    end

    // Response registers: loaded on the commit edge, cleared after handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_r <= 1'b0;
            rdata_r      <= 64'd0;
            err_r        <= 1'b0;
        end else if (commit_s) begin
            resp_valid_r <= 1'b1;
            err_r        <= err_s;
            rdata_r      <= (err_s || wen_r) ? 64'd0 : load_s;
        end else if ((state_r == RESP) && resp_ready) begin
            resp_valid_r <= 1'b0;
            rdata_r      <= 64'd0;
            err_r        <= 1'b0;
        end
    end

    // Byte-masked store commit; never written under reset or on error.
    always_ff @(posedge clk) begin
        if (!rst && commit_s && wen_r && !err_s) begin
            mem[idx_s] <= merged_s;
        end
    end

endmodule

// File: tb/tb_dmem_resp.sv
// Self-checking bench for dmem_resp: directed scenarios then randomized
// accesses compared against a byte-array reference model.
module tb_dmem_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [2:0]  req_size;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mem_b [0:2047];

    dmem_resp #(.ADDR_W(8), .LATENCY(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_size   (req_size),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: byte-addressed memory, rules applied arithmetically.
    task automatic model_ref(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                             input logic [2:0] size, output logic [63:0] rd, output logic er);
        int nb, off, base;
        logic [63:0] v;
        nb   = 1 << size[1:0];
        off  = int'(addr[2:0]);
        base = int'(addr[10:0]);
        er   = (size == 3'd7) || (wen && size[2]) || ((off % nb) != 0);
        rd   = 64'd0;
        if (!er) begin
            if (wen) begin
                for (int i = 0; i < nb; i++) mem_b[base + i] = wdata[8*i +: 8];
            end else begin
                v = 64'd0;
                for (int i = 0; i < nb; i++) v[8*i +: 8] = mem_b[base + i];
                if (!size[2] && nb < 8 && v[8*nb-1])
                    for (int i = nb; i < 8; i++) v[8*i +: 8] = 8'hFF;
                rd = v;
            end
        end
    endtask

    // One full transaction on the DUT, checked against the model.
    task automatic access(input string tag, input logic wen, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [2:0] size,
                          output logic [63:0] rd, output logic er);
        logic [63:0] exp_rd;
        logic        exp_er;
        int          cyc;
        model_ref(wen, addr, wdata, size, exp_rd, exp_er);
        @(negedge clk);
        check({tag, "/ready"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata; req_size = size;
        @(posedge clk);
        #1 req_valid = 1'b0;
        cyc = 0;
        while (cyc < 20) begin
            @(posedge clk);
            cyc++;
            #1;
            if (resp_valid) break;
        end
        check({tag, "/lat"}, 64'(cyc), 64'd2);
        rd = resp_rdata;
        er = resp_err;
        check({tag, "/rdata"}, resp_rdata, exp_rd);
        check({tag, "/err"}, 64'(resp_err), 64'(exp_er));
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        check({tag, "/vdrop"}, 64'(resp_valid), 64'd0);
    endtask

    initial begin
        logic [63:0] rd, exp_rd, snap;
        logic        er, exp_er;
        int          cyc;

        rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_addr = 64'd0;
        req_wdata = 64'd0; req_size = 3'd0; resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst/valid", 64'(resp_valid), 64'd0);
        check("rst/rdata", resp_rdata, 64'd0);
        check("rst/err", 64'(resp_err), 64'd0);
        check("rst/ready", 64'(req_ready), 64'd1);

        // Doubleword store then load-back.
        access("sd10", 1'b1, 64'h10, 64'h8877665544332211, 3'b011, rd, er);
        check("sd10/zero", rd, 64'd0);
        access("ld10", 1'b0, 64'h10, 64'd0, 3'b011, rd, er);
        check("ld10/const", rd, 64'h8877665544332211);

        // Sub-word loads with sign/zero extension.
        access("lb17", 1'b0, 64'h17, 64'd0, 3'b000, rd, er);
        check("lb17/const", rd, 64'hFFFFFFFFFFFFFF88);
        access("lbu17", 1'b0, 64'h17, 64'd0, 3'b100, rd, er);
        check("lbu17/const", rd, 64'h88);
        access("lh12", 1'b0, 64'h12, 64'd0, 3'b001, rd, er);
        check("lh12/const", rd, 64'h4433);
        access("lw14", 1'b0, 64'h14, 64'd0, 3'b010, rd, er);
        check("lw14/const", rd, 64'hFFFFFFFF88776655);
        access("lwu14", 1'b0, 64'h14, 64'd0, 3'b110, rd, er);
        check("lwu14/const", rd, 64'h88776655);

        // Byte store merges into the word.
        access("sb11", 1'b1, 64'h11, 64'hAB, 3'b000, rd, er);
        access("ld10b", 1'b0, 64'h10, 64'd0, 3'b011, rd, er);
        check("ld10b/const", rd, 64'h887766554433AB11);

        // Error cases.
        access("lw12", 1'b0, 64'h12, 64'd0, 3'b010, rd, er);
        check("lw12/errc", 64'(er), 64'd1);
        access("sd13", 1'b1, 64'h13, 64'hDEADBEEFDEADBEEF, 3'b011, rd, er);
        check("sd13/errc", 64'(er), 64'd1);
        access("ld10c", 1'b0, 64'h10, 64'd0, 3'b011, rd, er);
        check("ld10c/const", rd, 64'h887766554433AB11);
        access("sz7", 1'b0, 64'h10, 64'd0, 3'b111, rd, er);
        check("sz7/errc", 64'(er), 64'd1);
        access("sbu", 1'b1, 64'h10, 64'h55, 3'b100, rd, er);
        check("sbu/errc", 64'(er), 64'd1);

        // Back-pressure: response held, stray request ignored.
        model_ref(1'b0, 64'h10, 64'd0, 3'b011, exp_rd, exp_er);
        @(negedge clk);
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 64'h10; req_size = 3'b011;
        @(posedge clk);
        #1 req_valid = 1'b0;
        cyc = 0;
        while (cyc < 20 && !resp_valid) begin
            @(posedge clk);
            cyc++;
            #1;
        end
        check("stall/lat", 64'(cyc), 64'd2);
        snap = resp_rdata;
        check("stall/rdata0", snap, exp_rd);
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
                req_valid = 1'b1; req_wen = 1'b1; req_addr = 64'h10;
                req_wdata = 64'hFFFFFFFFFFFFFFFF; req_size = 3'b011;
            end
            @(posedge clk);
            #1 req_valid = 1'b0;
            check("stall/valid", 64'(resp_valid), 64'd1);
            check("stall/rdata", resp_rdata, exp_rd);
            check("stall/ready", 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        check("stall/vdrop", 64'(resp_valid), 64'd0);
        check("stall/ready1", 64'(req_ready), 64'd1);
        repeat (3) @(posedge clk);
        #1 check("stall/nostray", 64'(resp_valid), 64'd0);
        access("ld10d", 1'b0, 64'h10, 64'd0, 3'b011, rd, er);
        check("ld10d/const", rd, 64'h887766554433AB11);

        // Reset during WAIT aborts the pending store.
        @(negedge clk);
        req_valid = 1'b1; req_wen = 1'b1; req_addr = 64'h10;
        req_wdata = 64'h0123456789ABCDEF; req_size = 3'b011;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("abort/valid", 64'(resp_valid), 64'd0);
        check("abort/ready", 64'(req_ready), 64'd1);
        check("abort/rdata", resp_rdata, 64'd0);
        @(posedge clk);
        #1 check("abort/valid2", 64'(resp_valid), 64'd0);
        access("ld10e", 1'b0, 64'h10, 64'd0, 3'b011, rd, er);
        check("ld10e/const", rd, 64'h887766554433AB11);

        // Randomized: initialise 32 words (with wrapped upper bits), then mix.
        for (int w = 0; w < 32; w++) begin
            logic [63:0] a;
            a = {$urandom, $urandom};
            a[10:0] = 11'(w * 8);
            access("rinit", 1'b1, a, {$urandom, $urandom}, 3'b011, rd, er);
        end
        for (int n = 0; n < 150; n++) begin
            logic [63:0] a;
            logic        w;
            a = {$urandom, $urandom};
            a[10:8] = 3'b000;
            w = 1'($urandom_range(0, 1));
            access("rand", w, a, {$urandom, $urandom}, 3'($urandom_range(0, 7)), rd, er);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_resp.md
DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning log2 of the number of 64-bit words in the internal data RAM.
REQ-002 SHALL have parameter LATENCY, default 2, meaning cycles from request acceptance to resp_valid; legal range 1..15.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning the reset; it is synchronous and active-high.
REQ-005 SHALL have port req_valid, input, 1, meaning the execute stage presents a memory request.
REQ-006 SHALL have port req_ready, output, 1, meaning the block accepts a request this cycle.
REQ-007 SHALL have port req_wen, input, 1, meaning 1 = store, 0 = load.
REQ-008 SHALL have port req_addr, input, 64, meaning the byte address (the execute-stage ram_addr).
REQ-009 SHALL have port req_wdata, input, 64, meaning store data, right-aligned (LSB-justified).
REQ-010 SHALL have port req_size, input, 3, meaning RV64 funct3: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu.
REQ-011 SHALL have port resp_valid, output, 1, meaning the response is valid.
REQ-012 SHALL have port resp_ready, input, 1, meaning the consumer takes the response.
REQ-013 SHALL have port resp_rdata, output, 64, meaning load data after extension; 0 for stores and errors.
REQ-014 SHALL have port resp_err, output, 1, meaning the request was misaligned or had an illegal size.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-016 SHALL drive req_ready=1 only in IDLE.
REQ-017 SHALL, on req_valid&req_ready, latch wen/addr/wdata/size and enter WAIT with a down-counter loaded to LATENCY-1.
REQ-018 SHALL, in WAIT, decrement the counter each cycle and move to RESP on the edge where the counter is 0; resp_valid therefore rises exactly LATENCY cycles after the accepting edge.
REQ-019 SHALL, in RESP, hold resp_valid, resp_rdata and resp_err stable until resp_valid&resp_ready, then return to IDLE with resp_valid=0 on the next cycle.
REQ-020 SHALL NOT accept a new request in WAIT or RESP; one request is outstanding at most, and there is no IDLE-to-IDLE bypass.
REQ-021 SHALL index the RAM word with addr[ADDR_W+2:3] and the byte offset with addr[2:0]; upper address bits are ignored (wrap-around).
REQ-022 SHALL flag an error when the offset is not a multiple of the access size (h: off[0]; w: off[1:0]; d: off[2:0] nonzero), when size=111, or when a store has size[2]=1.
REQ-023 SHALL, on an error, perform no RAM write, return resp_rdata=0 and resp_err=1.
REQ-024 SHALL commit a legal store on the WAIT-to-RESP edge, writing only the bytes selected by size and offset, taking the data from wdata low bytes.
REQ-025 SHALL read a legal load on the WAIT-to-RESP edge, shift the selected bytes down, and sign-extend (size[2]=0) or zero-extend (size[2]=1) them to 64 bits.
REQ-026 SHALL ensure a load issued after a store to the same word observes the stored data.
REQ-027 SHALL drive resp_err=0 and resp_rdata=0 for a legal store response.

Reset
REQ-028 SHALL, while rst=1 at an edge, enter IDLE, clear the counter, and set resp_valid=0, resp_rdata=0 and resp_err=0; req_ready is 1 in the cycle after reset.
REQ-029 SHALL abort an in-flight request when rst is asserted in WAIT or RESP; a pending store that has not reached the commit edge is not written.
REQ-030 SHALL NOT reset RAM contents; the bench initialises RAM by stores before reading.

Verification
REQ-031 SHALL pass: sd addr 0x10 data 0x8877665544332211, then ld 0x10 -> rdata 0x8877665544332211, err 0, resp_valid rising 2 cycles after each accept.
REQ-032 SHALL pass: after REQ-031, lb 0x17 -> 0xFFFFFFFFFFFFFF88; lbu 0x17 -> 0x88; lh 0x12 -> 0x4433; lw 0x14 -> 0xFFFFFFFF88776655; lwu 0x14 -> 0x88776655.
REQ-033 SHALL pass: sb 0x11 data 0xAB, then ld 0x10 -> 0x887766554433AB11.
REQ-034 SHALL pass: lw 0x12 -> err 1, rdata 0; sd 0x13 -> err 1, with a later ld 0x10 unchanged; size 111 -> err 1.
REQ-035 SHALL pass: resp_ready held 0 for 5 cycles in RESP -> resp_valid/rdata stable, req_ready 0 throughout, and a req_valid pulse during this time is ignored.
REQ-036 SHALL pass: rst asserted one cycle after an sd is accepted (in WAIT) -> next cycle IDLE, resp_valid 0, and a subsequent ld of that word returns the old data.
